instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time writer for the instruction memory. Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Writes them sequentially into the instruction memory write port from address 0, then checks a trailing 32-bit additive checksum. Holds the CPU in reset (`cpu_hold`) until a load completes with a matching checksum; it sits between the host/UART byte source and port A of `INSTR_MEM`.

## Interface
- `ADDR_W`, 10, instruction memory address width (word addressed).
- `DEPTH`, 1024, memory depth in words; equals 2**ADDR_W.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- `num_words`  in  ADDR_W+1  number of instruction words to load; latched on accepted `start`.
- `in_valid`  in  1  byte source has data.
- `in_data`  in  8  byte payload.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs on an edge where `in_valid & in_ready`.
- `mem_wea`  out  1  memory write enable, one-cycle pulse per word.
- `mem_addra`  out  ADDR_W  memory word address.
- `mem_dina`  out  32  memory write data.
- `busy`  out  1  high in LOAD and CHECK.
- `done`  out  1  high in DONE.
- `err`  out  1  checksum mismatch or illegal `num_words`; valid while `done`.
- `cpu_hold`  out  1  CPU held in reset; low only after a successful load.

## Operation
- States: IDLE, LOAD, CHECK, DONE.
- IDLE: `start` with 1 <= `num_words` <= DEPTH latches the count and clears the word counter, byte counter and sum. Next state is LOAD, and `cpu_hold` is set to 1.
- IDLE: `start` with `num_words`=0 or > DEPTH goes to DONE with `err`=1. No writes occur and `cpu_hold` stays 1.
- LOAD: `in_ready`=1. Bytes are accepted MSB first into a 32-bit shift register (byte 0 -> bits 31:24).
- LOAD, on the 4th accepted byte of a word:
  - The word is registered to `mem_dina` and the word counter is registered to `mem_addra`, with `mem_wea`=1 for exactly the next cycle.
  - The sum is updated: sum <= sum + word, mod 2^32.
  - The word counter increments.
- LOAD: when the word just accepted is word `num_words`-1, next state is CHECK.
- CHECK: `in_ready`=1. Four bytes are accepted MSB first as the expected checksum. After the 4th byte, next state is DONE, with `err` = (received != sum).
- DONE: `done`=1, `busy`=0, `in_ready`=0. `cpu_hold` = `err`.
- DONE: `start` restarts exactly as from IDLE. `done` and `err` clear on the accepted start.
- `start` in LOAD/CHECK is ignored.
- Byte gaps (`in_valid`=0) of any length are allowed. Counters hold during gaps.
- Bytes offered in IDLE/DONE are not accepted (`in_ready`=0).
- Address never exceeds DEPTH-1. The word counter is ADDR_W+1 bits and is compared against `num_words`; `mem_addra` uses its low ADDR_W bits.
- Reset mid-operation:
  - All state returns to reset values, with no further writes.
  - Already-written memory words are not cleared.

## Timing
- Reset values:
  - `in_ready`=0, `mem_wea`=0, `mem_addra`=0, `mem_dina`=0.
  - `busy`=0, `done`=0, `err`=0, `cpu_hold`=1.
  - State IDLE.
- `start` accepted at edge t: `busy`=1 and `in_ready`=1 from t.
- 4th byte of a word accepted at edge k: `mem_wea`/`mem_addra`/`mem_dina` valid from k to k+1, and the memory writes at edge k+1.
- The next byte may be accepted at edge k+1 (no stall). Peak throughput is 1 byte/cycle.
- The last data word's 4th byte at edge k: state is CHECK from k, and its write pulse still occurs in the k..k+1 cycle.
- The last checksum byte at edge m: `done`=1, `err`, `cpu_hold` and `busy`=0 are valid from m.
- Minimum load time for N words is 4N+4 accepted-byte cycles, plus 1 start cycle.
- `mem_wea` is never high for two consecutive cycles when bytes arrive 1/cycle; this holds because a word takes 4 cycles minimum.

## Test plan
- **Basic load:**
  - Stimulus: `num_words`=2; bytes 00 00 00 13, DE AD BE EF, checksum DE AD BF 02.
  - Required: write addr 0 = 0x00000013, then addr 1 = 0xDEADBEEF.
  - Required: `done`=1, `err`=0, `cpu_hold`=0.
  - Required: reading `INSTR_MEM` at `addra` 0 and 1 returns those words.
- **Bad checksum:** same 2 words with checksum 00 00 00 00 -> both writes occur; `done`=1, `err`=1, `cpu_hold` stays 1.
- **Handshake gaps:** `in_valid` toggled randomly 50%, 1 word 0x12345678, checksum 12 34 56 78 -> exactly one `mem_wea` pulse with addr 0, data 0x12345678; `err`=0.
- **Illegal count:**
  - `num_words`=0 -> `done`=1, `err`=1, no `mem_wea`.
  - `num_words`=1025 -> same response.
- **Full depth:**
  - Stimulus: `num_words`=1024, word i = i; checksum 0x0007FE00.
  - Required: last write at addr 1023, no write after; `err`=0.
  - Required: `start` pulsed mid-load is ignored.
- **Reset mid-load:**
  - Stimulus: `rst` asserted after the 2nd byte of word 3.
  - Required: all outputs return to reset values immediately and no `mem_wea` follows.
  - Required: a subsequent 1-word load then succeeds.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Boot-time instruction memory loader: assembles big-endian words from a
// byte stream, writes them from address 0 and verifies a trailing checksum.
module instr_mem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_wea,
   output logic [ADDR_W-1:0] mem_addra,
   output logic [31:0]       mem_dina,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold
);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

   localparam logic [ADDR_W:0] MAXW = (ADDR_W+1)'(DEPTH);

   state_t          st;
   logic [ADDR_W:0] nwords;
   logic [ADDR_W:0] wcnt;
   logic [1:0]      bcnt;
   logic [23:0]     sh;
   logic [31:0]     sum;

   logic            xfer;
   logic            legal;
   logic [31:0]     word;

   always_comb begin
      xfer  = in_valid & in_ready;
      legal = (num_words != '0) && (num_words <= MAXW);
      word  = {sh, in_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= IDLE;
         nwords    <= '0;
         wcnt      <= '0;
         bcnt      <= '0;
         sh        <= '0;
         sum       <= '0;
         in_ready  <= 1'b0;
         mem_wea   <= 1'b0;
         mem_addra <= '0;
         mem_dina  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cpu_hold  <= 1'b1;
      end else begin
         mem_wea <= 1'b0;
         unique case (st)
            IDLE, DONE: begin
               if (start) begin
                  cpu_hold <= 1'b1;
                  if (legal) begin
                     st       <= LOAD;
                     nwords   <= num_words;
                     wcnt     <= '0;
                     bcnt     <= '0;
                     sum      <= '0;
                     busy     <= 1'b1;
                     in_ready <= 1'b1;
                     done     <= 1'b0;
                     err      <= 1'b0;
                  end else begin
                     st       <= DONE;
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     err      <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (xfer) begin
                  sh   <= {sh[15:0], in_data};
                  bcnt <= bcnt + 2'd1;
                  if (bcnt == 2'd3) begin
                     mem_wea   <= 1'b1;
                     mem_addra <= wcnt[ADDR_W-1:0];
                     mem_dina  <= word;
                     sum       <= sum + word;
                     wcnt      <= wcnt + 1'b1;
                     if (wcnt == nwords - 1'b1)
                        st <= CHECK;
                  end
               end
            end
            CHECK: begin
               if (xfer) begin
                  sh   <= {sh[15:0], in_data};
                  bcnt <= bcnt + 2'd1;
                  // the 4th byte completes the received checksum
                  if (bcnt == 2'd3) begin
                     st       <= DONE;
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     done     <= 1'b1;
                     err      <= (word != sum);
                     cpu_hold <= (word != sum);
                  end
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a
// word-list / arithmetic-checksum reference model.
module tb_instr_mem_loader;

   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   typedef logic [31:0] wq_t[$];

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   num_words = '0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_ready;
   logic          mem_wea;
   logic [AW-1:0] mem_addra;
   logic [31:0]   mem_dina;
   logic          busy;
   logic          done;
   logic          err;
   logic          cpu_hold;

   instr_mem_loader #(.ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .num_words(num_words),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
      .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // write monitor and memory stand-in
   logic [AW-1:0] wa_q[$];
   logic [31:0]   wd_q[$];
   int            b2b = 0;
   logic          prev_wea = 1'b0;
   logic [31:0]   tbmem [DEPTH];

   always @(negedge clk) begin
      if (mem_wea) begin
         wa_q.push_back(mem_addra);
         wd_q.push_back(mem_dina);
         if (prev_wea) b2b++;
      end
      prev_wea = mem_wea;
   end

   always @(posedge clk)
      if (mem_wea) tbmem[mem_addra] <= mem_dina;

   function automatic logic [31:0] model_sum(input wq_t w);
      logic [31:0] s = 0;
      foreach (w[i]) s = s + w[i];
      return s;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int to = 0;
      while (int'($urandom_range(99)) < gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && to < 50) begin
         @(negedge clk);
         to++;
      end
      chk("in_ready_wait", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8], gap);
      send_byte(w[7:0], gap);
   endtask

   task automatic do_start(input int n);
      start     = 1'b1;
      num_words = (AW+1)'(n);
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_wea"}, mem_wea, 0);
      chk({tag, "_addr"}, mem_addra, 0);
      chk({tag, "_din"}, mem_dina, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_hold"}, cpu_hold, 1);
   endtask

   task automatic run_load(input string tag, input wq_t words,
                           input logic [31:0] csum, input int gap,
                           input int pulse_at);
      logic exp_err;
      int   bad = 0;
      wa_q.delete();
      wd_q.delete();
      do_start(words.size());
      chk({tag, "_busy_start"}, busy, 1);
      chk({tag, "_rdy_start"}, in_ready, 1);
      foreach (words[i]) begin
         if (i == pulse_at) begin
            start     = 1'b1;
            num_words = 11'd3;
         end
         send_word(words[i], gap);
         start = 1'b0;
      end
      send_word(csum, gap);
      exp_err = (model_sum(words) != csum);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_hold"}, cpu_hold, exp_err);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rdy"}, in_ready, 0);
      repeat (3) @(negedge clk);
      chk({tag, "_nwrites"}, wa_q.size(), words.size());
      for (int i = 0; i < words.size(); i++) begin
         if (i >= wa_q.size()) bad++;
         else if (wa_q[i] != AW'(i) || wd_q[i] != words[i]) bad++;
      end
      chk({tag, "_bad_writes"}, bad, 0);
   endtask

   initial begin
      wq_t w;
      logic [31:0] cs;

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_accept", in_ready, 0);
      in_valid = 1'b0;

      // basic load
      w = '{32'h0000_0013, 32'hDEAD_BEEF};
      run_load("basic", w, 32'hDEAD_BF02, 0, -1);
      chk("mem0", tbmem[0], 32'h0000_0013);
      chk("mem1", tbmem[1], 32'hDEAD_BEEF);

      run_load("badsum", w, 32'h0, 0, -1);

      w = '{32'h1234_5678};
      run_load("gaps", w, 32'h1234_5678, 50, -1);

      // illegal counts
      wa_q.delete();
      do_start(0);
      chk("zero_done", done, 1);
      chk("zero_err", err, 1);
      chk("zero_hold", cpu_hold, 1);
      do_start(1025);
      chk("over_done", done, 1);
      chk("over_err", err, 1);
      chk("over_busy", busy, 0);
      repeat (3) @(negedge clk);
      chk("illegal_nwrites", wa_q.size(), 0);

      // full depth with ignored mid-load start
      w.delete();
      for (int i = 0; i < DEPTH; i++) w.push_back(32'(i));
      run_load("full", w, 32'h0007_FE00, 0, 500);
      chk("full_last_addr", wa_q[wa_q.size()-1], 1023);

      // randomized loads, good and bad checksums
      for (int t = 0; t < 6; t++) begin
         w.delete();
         for (int i = 0; i < int'($urandom_range(1, 8)); i++)
            w.push_back($urandom);
         cs = model_sum(w);
         if ($urandom_range(1)) cs = cs ^ (32'h1 << $urandom_range(31));
         run_load("rand", w, cs, $urandom_range(0, 60), -1);
      end

      // reset mid-load
      wa_q.delete();
      do_start(5);
      for (int i = 0; i < 3; i++) send_word($urandom, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst = 1'b1;
      #1;
      check_reset_vals("midrst");
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_nwrites", wa_q.size(), 3);
      w = '{32'hCAFE_F00D};
      run_load("postrst", w, 32'hCAFE_F00D, 20, -1);

      chk("wea_back_to_back", b2b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
